// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for load-use stalls,
// taken branches and halts, plus the debug run/step/halt FSM and perf counters.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int NB_CNT       = 32
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic [4:0]        i_id_rs1_addr,
    input  logic [4:0]        i_id_rs2_addr,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic              i_id_halt,
    input  logic              i_ex_memRead,
    input  logic [4:0]        i_ex_rd_addr,
    input  logic              i_ex_branch_taken,
    input  logic              i_dbg_run,
    input  logic              i_dbg_step,
    input  logic              i_dbg_stop,
    output logic              o_pc_en,
    output logic              o_if_id_en,
    output logic              o_if_id_flush,
    output logic              o_id_ex_en,
    output logic              o_id_ex_flush,
    output logic              o_ex_mem_en,
    output logic              o_mem_wb_en,
    output logic              o_halted,
    output logic [NB_CNT-1:0] o_stall_cnt,
    output logic [NB_CNT-1:0] o_cycle_cnt,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam int                DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [NB_CNT-1:0] CNT_MAX    = '1;

    state_t         state;
    logic [DCW-1:0] drain_cnt;
    logic           hz;
    logic           fl;
    logic           exec;
    logic           take_stall;
    logic           take_halt;

    // Priority inside RUN/STEP: branch flush, then load-use stall, then halt.
    always_comb begin
        hz = i_ex_memRead && (i_ex_rd_addr != 5'd0) &&
             ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
              (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));
        fl         = i_ex_branch_taken;
        exec       = (state == S_RUN) || (state == S_STEP);
        take_stall = exec && !fl && hz;
        take_halt  = exec && !fl && !hz && i_id_halt;
    end

    always_comb begin
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_en    = 1'b0;
        o_id_ex_flush = 1'b0;
        o_ex_mem_en   = 1'b0;
        o_mem_wb_en   = 1'b0;
        if (i_rst) begin
            // Flushing during reset clears the pipeline registers that have no reset.
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
        end else begin
            case (state)
                S_RUN, S_STEP: begin
                    o_id_ex_en  = 1'b1;
                    o_ex_mem_en = 1'b1;
                    o_mem_wb_en = 1'b1;
                    if (fl) begin
                        o_pc_en       = 1'b1;
                        o_if_id_en    = 1'b1;
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (hz) begin
                        o_id_ex_flush = 1'b1;
                    end else if (i_id_halt) begin
                        o_if_id_en    = 1'b1;
                        o_if_id_flush = 1'b1;
                    end else begin
                        o_pc_en    = 1'b1;
                        o_if_id_en = 1'b1;
                    end
                end
                S_DRAIN: begin
                    o_id_ex_en  = 1'b1;
                    o_ex_mem_en = 1'b1;
                    o_mem_wb_en = 1'b1;
                end
                default: begin
                    o_pc_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            drain_cnt   <= '0;
            o_halted    <= 1'b0;
            o_stall_cnt <= '0;
            o_cycle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_dbg_run) begin
                        state <= S_RUN;
                    end else if (i_dbg_step) begin
                        state <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (take_halt) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else if (i_dbg_stop) begin
                        state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    if (take_halt) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state    <= S_HALTED;
                        o_halted <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (exec && (o_cycle_cnt != CNT_MAX)) begin
                o_cycle_cnt <= o_cycle_cnt + 1'b1;
            end
            if (take_stall && (o_stall_cnt != CNT_MAX)) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
        end
    end

    assign o_dbg_state = state;

endmodule
